// File: rtl/mult_rom_arbiter.sv
// Two-requester front end for a multiplication-table ROM: one operand pair is granted
// round-robin, looked up as address {a,b}, and the product is returned to its requester.
module mult_rom_arbiter #(
  parameter int N      = 8,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic [N/2-1:0] req0_a,
  input  logic [N/2-1:0] req0_b,
  output logic           req0_ready,
  output logic           rsp0_valid,
  output logic [N-1:0]   rsp0_data,
  input  logic           req1_valid,
  input  logic [N/2-1:0] req1_a,
  input  logic [N/2-1:0] req1_b,
  output logic           req1_ready,
  output logic           rsp1_valid,
  output logic [N-1:0]   rsp1_data,
  output logic [N-1:0]   mem_address,
  output logic           mem_read_en,
  output logic           mem_ce,
  input  logic [N-1:0]   mem_data,
  output logic           busy,
  output logic [15:0]    op_count,
  output logic [1:0]     dbg_state
);

  // Handshake: a request transfers in the cycle where reqX_valid && reqX_ready; ready is
  // only ever offered in IDLE, to one requester. Responses are single-cycle pulses with
  // no backpressure; the requester must take rspX_data while rspX_valid is high.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] LP_LAST = 2'(RD_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_gnt;
  logic             w_read_done;
  logic [N/2-1:0]   w_sel_a;
  logic [N/2-1:0]   w_sel_b;

  logic [N/2-1:0]   r_a;
  logic [N/2-1:0]   r_b;
  logic             r_gid;
  logic             r_last_grant;
  logic [1:0]       r_rd_cnt;
  logic [N-1:0]     r_result;
  logic [N-1:0]     r_rsp0_data;
  logic [N-1:0]     r_rsp1_data;
  logic [15:0]      r_op_count;
  logic             r_mem_ce;
  logic             r_mem_rd;
  logic [N-1:0]     r_mem_addr;

  // Under contention the requester not served last wins; a lone requester always wins.
  assign w_gnt   = (req0_valid && req1_valid) ? ~r_last_grant : ~req0_valid;
  assign w_sel_a = w_gnt ? req1_a : req0_a;
  assign w_sel_b = w_gnt ? req1_b : req0_b;

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_read_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          w_accept = 1'b1;
          w_next   = S_READ;
        end
      end
      S_READ: begin
        if (r_rd_cnt == LP_LAST) begin
          w_read_done = 1'b1;
          w_next      = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_gid        <= 1'b0;
      r_last_grant <= 1'b1;
      r_rd_cnt     <= 2'd0;
      r_result     <= '0;
      r_rsp0_data  <= '0;
      r_rsp1_data  <= '0;
      r_op_count   <= 16'd0;
      r_mem_ce     <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= w_sel_a;
        r_b   <= w_sel_b;
        r_gid <= w_gnt;
      end
      r_rd_cnt <= (r_state == S_READ && w_next == S_READ) ? r_rd_cnt + 2'd1 : 2'd0;
      // Memory strobes are registered so they line up exactly with the READ cycles.
      r_mem_ce   <= (w_next == S_READ);
      r_mem_rd   <= (w_next == S_READ);
      if (w_next == S_READ) r_mem_addr <= w_accept ? {w_sel_a, w_sel_b} : {r_a, r_b};
      else                  r_mem_addr <= '0;
      if (w_read_done) r_result <= mem_data;
      if (r_state == S_RESP) begin
        if (r_gid) r_rsp1_data <= r_result;
        else       r_rsp0_data <= r_result;
        r_last_grant <= r_gid;
        r_op_count   <= r_op_count + 16'd1;
      end
    end
  end

  // Ready is gated by rst_n so it stays low while reset is held even with valid high.
  assign req0_ready  = rst_n & w_accept & ~w_gnt;
  assign req1_ready  = rst_n & w_accept &  w_gnt;
  assign rsp0_valid  = (r_state == S_RESP) & ~r_gid;
  assign rsp1_valid  = (r_state == S_RESP) &  r_gid;
  // The hold registers lag by one cycle, so the live result is muxed out during RESP.
  assign rsp0_data   = rsp0_valid ? r_result : r_rsp0_data;
  assign rsp1_data   = rsp1_valid ? r_result : r_rsp1_data;
  assign mem_ce      = r_mem_ce;
  assign mem_read_en = r_mem_rd;
  assign mem_address = r_mem_addr;
  assign busy        = (r_state != S_IDLE);
  assign op_count    = r_op_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mult_rom_arbiter.sv
// Directed bench for mult_rom_arbiter: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3,
// each with a combinational a*b ROM model on its memory port.
module tb_mult_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid [2];
  logic        req1_valid [2];
  logic [3:0]  req0_a [2];
  logic [3:0]  req0_b [2];
  logic [3:0]  req1_a [2];
  logic [3:0]  req1_b [2];
  logic        req0_ready [2];
  logic        req1_ready [2];
  logic        rsp0_valid [2];
  logic        rsp1_valid [2];
  logic [7:0]  rsp0_data [2];
  logic [7:0]  rsp1_data [2];
  logic [7:0]  mem_address [2];
  logic [7:0]  mem_data [2];
  logic        mem_read_en [2];
  logic        mem_ce [2];
  logic        busy [2];
  logic [15:0] op_count [2];
  logic [1:0]  dbg_state [2];

  int n_err;
  int n_chk;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    mult_rom_arbiter #(.N(8), .RD_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid[g]),
      .req0_a      (req0_a[g]),
      .req0_b      (req0_b[g]),
      .req0_ready  (req0_ready[g]),
      .rsp0_valid  (rsp0_valid[g]),
      .rsp0_data   (rsp0_data[g]),
      .req1_valid  (req1_valid[g]),
      .req1_a      (req1_a[g]),
      .req1_b      (req1_b[g]),
      .req1_ready  (req1_ready[g]),
      .rsp1_valid  (rsp1_valid[g]),
      .rsp1_data   (rsp1_data[g]),
      .mem_address (mem_address[g]),
      .mem_read_en (mem_read_en[g]),
      .mem_ce      (mem_ce[g]),
      .mem_data    (mem_data[g]),
      .busy        (busy[g]),
      .op_count    (op_count[g]),
      .dbg_state   (dbg_state[g])
    );
    assign mem_data[g] = {4'b0, mem_address[g][7:4]} * {4'b0, mem_address[g][3:0]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance to just after the next rising edge; registered outputs are settled there.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    n_err = 0;
    n_chk = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req0_valid[k] = 1'b0; req1_valid[k] = 1'b0;
      req0_a[k] = 4'h0; req0_b[k] = 4'h0; req1_a[k] = 4'h0; req1_b[k] = 4'h0;
    end
    req0_valid[0] = 1'b1;
    #3;
    // Reset state, with a request pending that must not see ready
    chk("rst_busy",      32'(busy[0]), 0);
    chk("rst_ready0",    32'(req0_ready[0]), 0);
    chk("rst_op_count",  32'(op_count[0]), 0);
    chk("rst_ce",        32'(mem_ce[1]), 0);
    chk("rst_state",     32'(dbg_state[0]), 0);
    chk("rst_rsp0_data", 32'(rsp0_data[0]), 0);
    req0_valid[0] = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;

    // Single request on RD_LAT=1: 3*5
    cyc();
    req0_valid[0] = 1'b1; req0_a[0] = 4'h3; req0_b[0] = 4'h5;
    #1;
    chk("s1_ready0", 32'(req0_ready[0]), 1);
    chk("s1_ready1", 32'(req1_ready[0]), 0);
    cyc();
    req0_valid[0] = 1'b0;
    chk("s1_ce",      32'(mem_ce[0]), 1);
    chk("s1_rd_en",   32'(mem_read_en[0]), 1);
    chk("s1_addr",    32'(mem_address[0]), 32'h35);
    chk("s1_state",   32'(dbg_state[0]), 1);
    cyc();
    chk("s1_rsp0_valid", 32'(rsp0_valid[0]), 1);
    chk("s1_rsp0_data",  32'(rsp0_data[0]), 32'h0F);
    chk("s1_rsp1_valid", 32'(rsp1_valid[0]), 0);
    chk("s1_ce_off",     32'(mem_ce[0]), 0);
    chk("s1_addr_off",   32'(mem_address[0]), 0);
    cyc();
    chk("s1_op_count",   32'(op_count[0]), 1);
    chk("s1_rsp0_low",   32'(rsp0_valid[0]), 0);
    chk("s1_rsp0_hold",  32'(rsp0_data[0]), 32'h0F);
    chk("s1_idle",       32'(busy[0]), 0);

    // Contention from reset: grants alternate 0,1,0,1
    rst_n = 1'b0;
    req0_valid[0] = 1'b1; req0_a[0] = 4'h2; req0_b[0] = 4'h7;
    req1_valid[0] = 1'b1; req1_a[0] = 4'h4; req1_b[0] = 4'h4;
    cyc();
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) cyc();
      g = (c / 3) % 2;
      chk("s2_both_ready", 32'(req0_ready[0] & req1_ready[0]), 0);
      if (c % 3 == 0)
        chk("s2_grant", 32'({req1_ready[0], req0_ready[0]}), (g == 1) ? 2 : 1);
      if (c % 3 == 2) begin
        chk("s2_rsp_valid", 32'({rsp1_valid[0], rsp0_valid[0]}), (g == 1) ? 2 : 1);
        chk("s2_rsp_data", (g == 1) ? 32'(rsp1_data[0]) : 32'(rsp0_data[0]),
            (g == 1) ? 32'h10 : 32'h0E);
      end
    end
    req0_valid[0] = 1'b0;
    req1_valid[0] = 1'b0;
    cyc();
    chk("s2_op_count", 32'(op_count[0]), 4);
    chk("s2_idle",     32'(busy[0]), 0);

    // Boundary operands on RD_LAT=3: 15*15
    cyc();
    req1_valid[1] = 1'b1; req1_a[1] = 4'hF; req1_b[1] = 4'hF;
    #1;
    chk("s3_ready1", 32'(req1_ready[1]), 1);
    chk("s3_ready0", 32'(req0_ready[1]), 0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      req1_valid[1] = 1'b0;
      chk("s3_ce",   32'(mem_ce[1]), 1);
      chk("s3_addr", 32'(mem_address[1]), 32'hFF);
      chk("s3_rsp1_early", 32'(rsp1_valid[1]), 0);
    end
    cyc();
    chk("s3_ce_off",     32'(mem_ce[1]), 0);
    chk("s3_rsp1_valid", 32'(rsp1_valid[1]), 1);
    chk("s3_rsp1_data",  32'(rsp1_data[1]), 32'hE1);
    chk("s3_rsp0_valid", 32'(rsp0_valid[1]), 0);
    cyc();
    chk("s3_op_count",   32'(op_count[1]), 1);

    // Reset in the middle of a RD_LAT=3 read
    cyc();
    req0_valid[1] = 1'b1; req0_a[1] = 4'h2; req0_b[1] = 4'h3;
    #1;
    chk("s4_ready0", 32'(req0_ready[1]), 1);
    cyc();
    req0_valid[1] = 1'b0;
    chk("s4_ce_read", 32'(mem_ce[1]), 1);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("s4_ce_rst",    32'(mem_ce[1]), 0);
    chk("s4_busy_rst",  32'(busy[1]), 0);
    chk("s4_addr_rst",  32'(mem_address[1]), 0);
    chk("s4_opcnt_rst", 32'(op_count[1]), 0);
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("s4_no_rsp", 32'({rsp1_valid[1], rsp0_valid[1]}), 0);
    end
    chk("s4_op_count", 32'(op_count[1]), 0);
    chk("s4_rsp0_data", 32'(rsp0_data[1]), 0);

    // Operand change while busy is ignored: 6*7 even though a becomes 1
    cyc();
    req0_valid[0] = 1'b1; req0_a[0] = 4'h6; req0_b[0] = 4'h7;
    #1;
    chk("s5_ready0", 32'(req0_ready[0]), 1);
    cyc();
    req0_a[0] = 4'h1;
    #1;
    chk("s5_ready_busy", 32'(req0_ready[0]), 0);
    chk("s5_addr",       32'(mem_address[0]), 32'h67);
    cyc();
    chk("s5_ready_resp", 32'(req0_ready[0]), 0);
    chk("s5_rsp0_valid", 32'(rsp0_valid[0]), 1);
    chk("s5_rsp0_data",  32'(rsp0_data[0]), 32'h2A);
    req0_valid[0] = 1'b0;
    cyc();
    chk("s5_op_count", 32'(op_count[0]), 1);

    // op_count wrap: preload 0xFFFF, then one lookup of 1*1
    force gen_dut[0].u_dut.r_op_count = 16'hFFFF;
    #1;
    release gen_dut[0].u_dut.r_op_count;
    #1;
    chk("s5_preload", 32'(op_count[0]), 32'hFFFF);
    cyc();
    req0_valid[0] = 1'b1; req0_a[0] = 4'h1; req0_b[0] = 4'h1;
    cyc();
    req0_valid[0] = 1'b0;
    cyc();
    chk("s5_wrap_data", 32'(rsp0_data[0]), 32'h01);
    cyc();
    chk("s5_wrap_count", 32'(op_count[0]), 0);
    chk("s5_wrap_idle",  32'(busy[0]), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
